bitstream_loader: RTL

Serial configuration master for the fabric's programming chain. It accepts the configuration bitstream as 32-bit words over a valid/ready stream and shifts it, MSB first, into the core's daisy-chained `prog_in`/`prog_en` port. It can then run a non-destructive readback pass, recirculating the chain's `prog_out` into `prog_in` and checking the returned bits against a CRC computed during load. It sits between the host/boot interface and the core, and is clocked by the programming clock.

---
 rtl/bitstream_pkg.sv | 22 ++
 rtl/crc16_serial.sv | 39 +++
 rtl/bitstream_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bitstream_pkg.sv
// Shared types and constants for the fabric configuration loader.
package bitstream_pkg;

    localparam int          WORD_W     = 32;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_READBACK = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // One serial CRC-16-CCITT step, MSB-first, no reflection.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear and enable.
module crc16_serial
    import bitstream_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: clear wins over a data step.
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC16_INIT;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/bitstream_loader.sv
// Serial configuration master: shifts 32-bit words MSB-first into the fabric
// programming chain, then optionally rotates the chain once to verify its CRC.
module bitstream_loader
    import bitstream_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int VERIFY    = 1
) (
    input  logic        prog_clk,
    input  logic        prog_rst,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        prog_data_o,
    output logic        prog_en_o,
    input  logic        prog_ret_i,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] crc_o
);

    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - WORD_W * (NWORDS - 1);
    localparam int CW        = $clog2(CHAIN_LEN + 1);
    localparam int WW        = $clog2(NWORDS + 1);

    localparam logic [5:0]    LAST_BITS_V = 6'(LAST_BITS);
    localparam logic [CW-1:0] CHAIN_LEN_V = CW'(CHAIN_LEN);
    localparam logic [WW-1:0] NWORDS_V    = WW'(NWORDS);

    state_e        state_q,  state_d;
    logic [31:0]   shreg_q,  shreg_d;
    logic [5:0]    bits_q,   bits_d;
    logic [WW-1:0] words_q,  words_d;
    logic [CW-1:0] remain_q, remain_d;
    logic          error_q,  error_d;

    logic        start_s;
    logic        shift_s;
    logic        accept_s;
    logic        rb_s;
    logic [15:0] load_crc_s;
    logic [15:0] rb_crc_s;

    assign start_s  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign shift_s  = (state_q == ST_LOAD) && (bits_q != 6'd0);
    assign rb_s     = (state_q == ST_READBACK);
    // The next word is fetched while the last bit of the current one shifts.
    assign s_ready  = (state_q == ST_LOAD) && (words_q != WW'(0)) && (bits_q <= 6'd1);
    assign accept_s = s_valid && s_ready;

    assign prog_en_o   = shift_s || rb_s;
    assign prog_data_o = (state_q == ST_LOAD) ? shreg_q[31] : (rb_s ? prog_ret_i : 1'b0);
    assign busy        = (state_q == ST_LOAD) || rb_s;
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;
    assign crc_o       = load_crc_s;

    crc16_serial u_load_crc (
        .clk_i (prog_clk),
        .rst_i (prog_rst),
        .clr_i (start_s),
        .en_i  (shift_s),
        .bit_i (shreg_q[31]),
        .crc_o (load_crc_s)
    );

    crc16_serial u_rb_crc (
        .clk_i (prog_clk),
        .rst_i (prog_rst),
        .clr_i (start_s),
        .en_i  (rb_s),
        .bit_i (prog_ret_i),
        .crc_o (rb_crc_s)
    );

    // Next-state logic for the load/readback sequencer.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bits_d   = bits_q;
        words_d  = words_q;
        remain_d = remain_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    shreg_d  = 32'h0000_0000;
                    bits_d   = 6'd0;
                    words_d  = NWORDS_V;
                    remain_d = CHAIN_LEN_V;
                    error_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                // A fetched word overrides the shift of the outgoing bit.
                if (accept_s) begin
                    shreg_d = s_data;
                    bits_d  = (words_q == WW'(1)) ? LAST_BITS_V : 6'd32;
                    words_d = words_q - WW'(1);
                end else if (shift_s) begin
                    shreg_d = {shreg_q[30:0], 1'b0};
                    bits_d  = bits_q - 6'd1;
                end else begin
                    shreg_d = shreg_q;
                end
                if (shift_s) begin
                    if (remain_q == CW'(1)) begin
                        state_d  = (VERIFY != 0) ? ST_READBACK : ST_DONE;
                        remain_d = CHAIN_LEN_V;
                    end else begin
                        remain_d = remain_q - CW'(1);
                    end
                end else begin
                    remain_d = remain_q;
                end
            end
            ST_READBACK: begin
                if (remain_q == CW'(1)) begin
                    state_d  = ST_DONE;
                    remain_d = CW'(0);
                    error_d  = (crc16_step(rb_crc_s, prog_ret_i) != load_crc_s);
                end else begin
                    remain_d = remain_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= 32'h0000_0000;
            bits_q   <= 6'd0;
            words_q  <= WW'(0);
            remain_q <= CW'(0);
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bits_q   <= bits_d;
            words_q  <= words_d;
            remain_q <= remain_d;
            error_q  <= error_d;
        end
    end

endmodule
